// File: rtl/spike_router.sv
// 5-port XY mesh router: per-input FIFO, per-output round-robin arbiter and output register.
// Latency: one edge from FIFO push to out_valid. in_ready is registered !full; off-mesh heads are dropped and counted.
module spike_router #(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int FW = XW + YW + DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5*FW-1:0] in_flit,
  input  logic [4:0]    in_valid,
  output logic [4:0]    in_ready,
  output logic [5*FW-1:0] out_flit,
  output logic [4:0]    out_valid,
  input  logic [4:0]    out_ready,
  output logic [15:0]   drop_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   FULL = FIFO_DEPTH[AW:0];
  localparam logic [XW-1:0] XID  = X_ID[XW-1:0];
  localparam logic [YW-1:0] YID  = Y_ID[YW-1:0];
  localparam bit EDGE_E = (X_ID == COLS - 1);
  localparam bit EDGE_W = (X_ID == 0);
  localparam bit EDGE_N = (Y_ID == 0);
  localparam bit EDGE_S = (Y_ID == ROWS - 1);

  logic [FW-1:0] head [5];
  logic [2:0]    route [5];
  logic [4:0]    req_ok;
  logic [4:0]    drop;
  logic [4:0]    pop;
  logic [4:0]    gvec [5];

  for (genvar p = 0; p < 5; p++) begin : g_in
    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt, cnt_nx;
    logic          rdy_r, push, hv, off;
    logic [2:0]    dir;
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;

    assign push        = in_valid[p] & rdy_r;
    assign in_ready[p] = rdy_r;
    assign hv          = (cnt != '0);
    assign head[p]     = mem[rp];
    assign dx          = mem[rp][FW-1 -: XW];
    assign dy          = mem[rp][DATA_WIDTH +: YW];

    always_comb begin
      cnt_nx = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop[p]};
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wp    <= '0;
        rp    <= '0;
        cnt   <= '0;
        rdy_r <= 1'b0;
      end else begin
        if (push)   wp <= wp + 1'b1;
        if (pop[p]) rp <= rp + 1'b1;
        cnt   <= cnt_nx;
        rdy_r <= (cnt_nx != FULL);
      end
    end

    // Storage needs no reset: the counter alone defines what is valid.
    always_ff @(posedge clk) begin
      if (push) mem[wp] <= in_flit[p*FW +: FW];
    end

    always_comb begin
      dir = 3'd0;
      off = 1'b0;
      if (dx > XID) begin
        dir = 3'd2;
        off = EDGE_E;
      end else if (dx < XID) begin
        dir = 3'd4;
        off = EDGE_W;
      end else if (dy > YID) begin
        dir = 3'd3;
        off = EDGE_S;
      end else if (dy < YID) begin
        dir = 3'd1;
        off = EDGE_N;
      end
    end

    assign route[p]  = dir;
    assign req_ok[p] = hv & ~off;
    assign drop[p]   = hv & off;
  end

  for (genvar o = 0; o < 5; o++) begin : g_out
    logic [4:0]    req;
    logic [2:0]    ptr, gidx;
    logic          gany, accept, ovld;
    logic [FW-1:0] oflit;
    int            j;

    assign accept = ~ovld | out_ready[o];

    always_comb begin
      for (int i = 0; i < 5; i++) req[i] = req_ok[i] && (route[i] == 3'(o));
    end

    // Round-robin: scan upward from ptr, wrapping 4 -> 0.
    always_comb begin
      gany = 1'b0;
      gidx = ptr;
      j    = 0;
      for (int k = 0; k < 5; k++) begin
        j = int'(ptr) + k;
        if (j >= 5) j = j - 5;
        if (!gany && accept && req[j[2:0]]) begin
          gany = 1'b1;
          gidx = j[2:0];
        end
      end
    end

    always_comb begin
      gvec[o] = '0;
      if (gany) gvec[o][gidx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ovld  <= 1'b0;
        oflit <= '0;
        ptr   <= '0;
      end else if (gany) begin
        ovld  <= 1'b1;
        oflit <= head[gidx];
        ptr   <= (gidx == 3'd4) ? 3'd0 : gidx + 3'd1;
      end else if (out_ready[o]) begin
        ovld  <= 1'b0;
      end
    end

    assign out_valid[o]        = ovld;
    assign out_flit[o*FW +: FW] = oflit;
  end

  // Each head routes to exactly one output, so grants never collide on an input.
  always_comb begin
    pop = drop;
    for (int o = 0; o < 5; o++) pop = pop | gvec[o];
  end

  logic [15:0] dcnt;
  logic [16:0] dsum;

  always_comb begin
    dsum = {1'b0, dcnt};
    for (int i = 0; i < 5; i++) dsum = dsum + {16'd0, drop[i]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dcnt <= '0;
    else      dcnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
  end

  assign drop_count = dcnt;

endmodule

// File: tb/tb_spike_router.sv
// Directed bench for spike_router on a 3x3 mesh: centre router (1,1) plus an east-edge router (2,1).
module tb_spike_router;

  localparam int FW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [5*FW-1:0] in_flit;
  logic [4:0]    in_valid;
  logic [4:0]    in_ready;
  logic [5*FW-1:0] out_flit;
  logic [4:0]    out_valid;
  logic [4:0]    out_ready;
  logic [15:0]   drop_count;

  logic [4:0]    e_in_ready;
  logic [5*FW-1:0] e_out_flit;
  logic [4:0]    e_out_valid;
  logic [15:0]   e_drop_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spike_router #(.ROWS(3), .COLS(3), .X_ID(1), .Y_ID(1), .DATA_WIDTH(8), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .drop_count(drop_count)
  );

  spike_router #(.ROWS(3), .COLS(3), .X_ID(2), .Y_ID(1), .DATA_WIDTH(8), .FIFO_DEPTH(4)) u_edge (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_valid(in_valid), .in_ready(e_in_ready),
    .out_flit(e_out_flit), .out_valid(e_out_valid), .out_ready(out_ready),
    .drop_count(e_drop_count)
  );

  function automatic logic [FW-1:0] mk(input int x, input int y, input int pl);
    logic [1:0] xb, yb;
    logic [7:0] pb;
    xb = x[1:0];
    yb = y[1:0];
    pb = pl[7:0];
    return {xb, yb, pb};
  endfunction

  function automatic logic [FW-1:0] port_of(input logic [5*FW-1:0] v, input int p);
    return v[p*FW +: FW];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int p, input logic [FW-1:0] f);
    in_flit[p*FW +: FW] = f;
  endtask

  int   acc;
  logic [4:0] seen;

  initial begin
    rst       = 1'b0;
    in_flit   = '0;
    in_valid  = '0;
    out_ready = 5'h1F;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_drop", 32'(drop_count), 32'h0);
    rst = 1'b1;
    tick();
    check("rdy_after_release", 32'(in_ready), 32'h1F);

    // Local -> East, one-edge latency
    set_in(0, mk(2, 1, 8'hA5));
    in_valid = 5'b00001;
    tick();
    in_valid = '0;
    check("lat_not_early", 32'(out_valid), 32'h0);
    tick();
    check("lat_east_valid", 32'(out_valid), 32'h04);
    check("lat_east_flit", 32'(port_of(out_flit, 2)), 32'(mk(2, 1, 8'hA5)));
    tick();
    check("lat_drained", 32'(out_valid), 32'h0);

    // North and West tie for Local, twice back to back
    set_in(1, mk(1, 1, 8'h11));
    set_in(4, mk(1, 1, 8'h44));
    in_valid = 5'b10010;
    tick();
    set_in(1, mk(1, 1, 8'h22));
    set_in(4, mk(1, 1, 8'h55));
    tick();
    in_valid = '0;
    check("rr_v1", 32'(out_valid), 32'h01);
    check("rr_n1", 32'(port_of(out_flit, 0)), 32'(mk(1, 1, 8'h11)));
    tick();
    check("rr_w1", 32'(port_of(out_flit, 0)), 32'(mk(1, 1, 8'h44)));
    tick();
    check("rr_n2", 32'(port_of(out_flit, 0)), 32'(mk(1, 1, 8'h22)));
    tick();
    check("rr_w2", 32'(port_of(out_flit, 0)), 32'(mk(1, 1, 8'h55)));
    tick();
    check("rr_idle", 32'(out_valid), 32'h0);

    // Backpressure on East: 5 of 6 accepted, then drain in order
    out_ready = 5'b11011;
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      set_in(0, mk(2, 1, i));
      in_valid = 5'b00001;
      if (in_ready[0]) acc++;
      tick();
    end
    in_valid = '0;
    check("bp_accepted", 32'(acc), 32'd5);
    check("bp_full", 32'(in_ready[0]), 32'h0);
    check("bp_hold_v", 32'(out_valid[2]), 32'h1);
    check("bp_hold_1", 32'(port_of(out_flit, 2)), 32'(mk(2, 1, 1)));
    tick();
    tick();
    check("bp_stable", 32'(port_of(out_flit, 2)), 32'(mk(2, 1, 1)));
    out_ready = 5'h1F;
    for (int i = 2; i <= 5; i++) begin
      tick();
      check($sformatf("bp_seq%0d", i), 32'(port_of(out_flit, 2)), 32'(mk(2, 1, i)));
      check($sformatf("bp_vld%0d", i), 32'(out_valid[2]), 32'h1);
    end
    tick();
    check("bp_empty", 32'(out_valid), 32'h0);
    check("bp_rdy_back", 32'(in_ready), 32'h1F);

    // Off-mesh destination on the east-edge router
    set_in(0, mk(3, 1, 8'h77));
    in_valid = 5'b00001;
    seen = '0;
    tick();
    in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      seen = seen | e_out_valid;
      tick();
    end
    check("drop_no_out", 32'(seen), 32'h0);
    check("drop_count", 32'(e_drop_count), 32'd1);
    check("drop_rdy", 32'(e_in_ready), 32'h1F);
    check("ctr_no_drop", 32'(drop_count), 32'd0);

    // Reset mid-transfer with West blocked
    out_ready = 5'b01111;
    for (int i = 1; i <= 4; i++) begin
      set_in(0, mk(0, 1, 8'hC0 + i));
      in_valid = 5'b00001;
      tick();
    end
    in_valid = '0;
    tick();
    check("pre_rst_west", 32'(out_valid[4]), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_flit", 32'(out_flit), 32'h0);
    check("arst_rdy", 32'(in_ready), 32'h0);
    check("arst_drop", 32'(e_drop_count), 32'h0);
    tick();
    rst = 1'b1;
    out_ready = 5'h1F;
    tick();
    check("post_rst_rdy", 32'(in_ready), 32'h1F);
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | out_valid;
      tick();
    end
    check("post_rst_quiet", 32'(seen), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
